dmem_bytelane: RTL

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

---
 rtl/dmem_bytelane_if.sv | 16 +
 rtl/dmem_bytelane.sv | 89 ++++++++
 2 files changed

// File: rtl/dmem_bytelane_if.sv
// dmem_bytelane_if: request/response bundle between a load/store unit and the byte-lane data memory.
interface dmem_bytelane_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              busy;
  logic              misalign;
  modport master (output req, we, funct3, addr, wdata, input rdata, ready, busy, misalign);
  modport slave (input req, we, funct3, addr, wdata, output rdata, ready, busy, misalign);
endinterface

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: fixed-latency RV32 data memory with byte/half/word lanes, extension and misalignment faults.
module dmem_bytelane #(
  parameter int ADDR_W = 8,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst,
  dmem_bytelane_if.slave bus
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  logic l_we;
  logic [2:0] l_f3;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0] l_wdata;
  logic fault;
  logic [1:0] lane;
  logic [ADDR_W-3:0] widx;
  logic [3:0] be;
  logic [31:0] wd_sh, rw, ld;
  always_comb begin
    fault = ((bus.funct3 == 3'b001 || bus.funct3 == 3'b101) && bus.addr[0])
         || (bus.funct3 == 3'b010 && bus.addr[1:0] != 2'b00)
         || bus.funct3 == 3'b011 || bus.funct3 == 3'b110 || bus.funct3 == 3'b111
         || (bus.we && bus.funct3[2]);
  end
  assign lane = l_addr[1:0];
  assign widx = l_addr[ADDR_W-1:2];
  assign wd_sh = l_wdata << {lane, 3'b000};
  assign rw = mem[widx] >> {lane, 3'b000};
  always_comb begin
    be = l_f3[1:0] == 2'b00 ? 4'b0001 << lane : l_f3[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
    ld = l_f3 == 3'b000 ? {{24{rw[7]}}, rw[7:0]}
       : l_f3 == 3'b001 ? {{16{rw[15]}}, rw[15:0]}
       : l_f3 == 3'b100 ? {24'd0, rw[7:0]}
       : l_f3 == 3'b101 ? {16'd0, rw[15:0]}
       : rw;
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.ready <= 1'b0;
      bus.misalign <= 1'b0;
      bus.rdata <= '0;
      l_we <= 1'b0;
      l_f3 <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      bus.ready <= 1'b0;
      bus.misalign <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          l_we <= bus.we;
          l_f3 <= bus.funct3;
          l_addr <= bus.addr;
          l_wdata <= bus.wdata;
          if (fault) begin
            state <= DONE;
            bus.ready <= 1'b1;
            bus.misalign <= 1'b1;
          end else begin
            state <= WAIT;
            cnt <= 4'(LATENCY - 1);
          end
        end
        WAIT: if (cnt == 4'd0) begin
          // Access uses only the request latched at acceptance; live bus inputs are ignored here.
          if (l_we) begin
            for (int i = 0; i < 4; i++) if (be[i]) mem[widx][8*i +: 8] <= wd_sh[8*i +: 8];
          end else begin
            bus.rdata <= ld;
          end
          state <= DONE;
          bus.ready <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
